// File: rtl/seven_seg_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment driver.
// Glyph bit order is {a,b,c,d,e,f,g}, active-high before polarity is applied.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to seven-segment glyph lookup with forced blank.
module seven_seg_decode (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);
  import seven_seg_pkg::*;

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      unique case (nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        4'hF: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment scanner with double-buffered display data.
// Define SEVEN_SEG_LZB_EN to blank leading-zero digits (digit 0 always shown).
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               enable,
  input  logic [4*NUM_DIGITS-1:0]                            value,
  input  logic [NUM_DIGITS-1:0]                              dp_in,
  input  logic                                               load,
  output logic [6:0]                                         seg,
  output logic                                               dp,
  output logic [NUM_DIGITS-1:0]                              an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                               frame_done
);
  import seven_seg_pkg::*;

  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
  localparam state_e        FIRST      = (BLANK_CYCLES > 0) ? BLANK : SHOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]    SEG_IDLE   = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic          DP_OFF     = (SEG_ACTIVE_LOW != 0);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fd_q, fd_d;

  logic                    commit;
  logic                    show;
  logic                    lzb;
  logic [3:0]              nib;
  logic [6:0]              glyph;

  // Buffers and scan FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;

    commit = (state_q == IDLE) || fd_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      if (commit) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
        pend_d     = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (commit && pend_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pend_d     = 1'b0;
    end

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FIRST;
          cnt_d   = '0;
          digit_d = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = FIRST;
            cnt_d   = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          digit_d = '0;
        end
      endcase
    end

    fd_d = (state_d == SHOW) && (digit_d == DIG_LAST) && (cnt_d == SLOT_LAST);
  end

  // Outputs are derived from next-state so they change on the same edge as the state
  always_comb begin
    show = (state_d == SHOW);
    nib  = disp_val_d[4*digit_d +: 4];
`ifdef SEVEN_SEG_LZB_EN
    lzb  = (digit_d != '0) && ((disp_val_d >> (4 * digit_d)) == '0);
`else
    lzb  = 1'b0;
`endif
  end

  seven_seg_decode u_decode (
    .nibble (nib),
    .blank  (!show || lzb),
    .seg    (glyph)
  );

  always_comb begin
    an_d = AN_OFF;
    if (show) an_d[digit_d] = ~AN_OFF[digit_d];
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
    dp_d  = (show && disp_dp_d[digit_d]) ^ DP_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      digit_q    <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_IDLE;
      dp_q       <= DP_OFF;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digit_idx  = digit_q;
  assign frame_done = fd_q;

endmodule
